// File: rtl/map_loader.sv
`default_nettype none
// ============================================================================
// Module   : map_loader
// Picks a puzzle index from the free-running LFSR, then copies that puzzle's
// cells from the puzzle ROM into the board RAM.
// Revision : 1.0
// ============================================================================
module map_loader #(
    parameter int NUM_MAPS = 8,
    parameter int CELLS    = 81,
    parameter int ROM_AW   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        random_number,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic              board_we,
    output logic [6:0]        board_addr,
    output logic [3:0]        board_data,
    output logic [2:0]        map_select,
    output logic              map_loaded,
    output logic              busy,
    output logic [6:0]        cells_given
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_READ   = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Bit i set when puzzle index i exists in the ROM.
    localparam logic [7:0] c_valid_mask = 8'((1 << NUM_MAPS) - 1);
    localparam logic [6:0] c_last_cell  = 7'(CELLS - 1);

    state_t     r_state;
    logic [6:0] r_cell;
    logic       r_have_prev;
    logic       w_accept;
    logic       w_clue;

    assign w_accept = c_valid_mask[random_number] &&
                      !(r_have_prev && (random_number == map_select));

    assign w_clue = board_we && (rom_data != 4'd0);

    // ROM data is already registered one cycle after its address, so it lines
    // up with the registered write strobe and address without another stage.
    assign board_data = board_we ? rom_data : 4'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cell      <= '0;
            r_have_prev <= 1'b0;
            map_loaded  <= 1'b0;
            busy        <= 1'b0;
            board_we    <= 1'b0;
            rom_addr    <= '0;
            board_addr  <= '0;
            map_select  <= '0;
            cells_given <= '0;
        end else begin
            board_we <= 1'b0;
            if (w_clue) begin
                cells_given <= cells_given + 7'd1;
            end

            case (r_state)
                S_IDLE: begin
                    map_loaded <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        r_state <= S_SELECT;
                    end
                end

                S_SELECT: begin
                    if (w_accept) begin
                        map_select  <= random_number;
                        rom_addr    <= ROM_AW'(CELLS * int'(random_number));
                        r_cell      <= '0;
                        cells_given <= '0;
                        r_state     <= S_READ;
                    end
                end

                S_READ: begin
                    board_we   <= 1'b1;
                    board_addr <= r_cell;
                    if (r_cell == c_last_cell) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_cell   <= r_cell + 7'd1;
                        rom_addr <= rom_addr + 1'b1;
                    end
                end

                S_DRAIN: begin
                    busy        <= 1'b0;
                    map_loaded  <= 1'b1;
                    r_have_prev <= 1'b1;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    if (start) begin
                        map_loaded <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= S_SELECT;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_map_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_loader
// Randomised scoreboard bench for map_loader with ROM, board RAM and LFSR models.
// Revision : 1.0
// ============================================================================
module tb_map_loader;

    localparam int NUM_MAPS = 4;
    localparam int CELLS    = 81;
    localparam int ROM_AW   = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        random_number;
    logic [ROM_AW-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic              board_we;
    logic [6:0]        board_addr;
    logic [3:0]        board_data;
    logic [2:0]        map_select;
    logic              map_loaded;
    logic              busy;
    logic [6:0]        cells_given;

    always #5 clk = ~clk;

    map_loader #(
        .NUM_MAPS (NUM_MAPS),
        .CELLS    (CELLS),
        .ROM_AW   (ROM_AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .random_number (random_number),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .board_we      (board_we),
        .board_addr    (board_addr),
        .board_data    (board_data),
        .map_select    (map_select),
        .map_loaded    (map_loaded),
        .busy          (busy),
        .cells_given   (cells_given)
    );

    // Environment: synchronous ROM, board RAM, LFSR frozen by map_loaded.
    logic [3:0] rom   [0:1023];
    logic [3:0] board [0:127];
    logic [2:0] lfsr;
    logic       seed_en = 1'b0;
    logic [2:0] seed_val = 3'd1;

    function automatic int next_of(input int v);
        case (v)
            1: return 2;
            2: return 5;
            5: return 3;
            3: return 7;
            7: return 6;
            6: return 4;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) if (board_we) board[board_addr] <= board_data;
    always @(posedge clk) begin
        if (reset)            lfsr <= 3'd1;
        else if (seed_en)     lfsr <= seed_val;
        else if (!map_loaded) lfsr <= 3'(next_of(int'(lfsr)));
    end
    assign random_number = lfsr;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int addr; int data; } wr_t;
    typedef struct { int map; int cells; int cyc; } done_t;
    wr_t   wr_q[$];
    done_t done_q[$];

    int errors = 0;
    int checks = 0;

    int prev = 0;
    bit have_prev = 1'b0;
    bit model_loaded = 1'b0;
    int model_done_cyc = 0;
    int ml_rise_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every board write and every load completion is matched
    // against what the stimulus side queued.
    wr_t   mw;
    done_t md;
    int    mbad;
    logic  ml_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (board_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    mw = wr_q.pop_front();
                    check("wr_cycle", cyc, mw.cyc);
                    check("wr_addr", int'(board_addr), mw.addr);
                    check("wr_data", int'(board_data), mw.data);
                end
            end
            if (map_loaded && !ml_prev) begin
                ml_rise_cyc = cyc;
                if (done_q.size() == 0) begin
                    check("unexpected_map_loaded", 1, 0);
                end else begin
                    md = done_q.pop_front();
                    check("done_cycle", cyc, md.cyc);
                    check("map_select", int'(map_select), md.map);
                    check("cells_given", int'(cells_given), md.cells);
                    check("busy_at_done", int'(busy), 0);
                    mbad = 0;
                    for (int k = 0; k < CELLS; k++)
                        if (board[k] !== rom[md.map * CELLS + k]) mbad++;
                    check("board_bad_cells", mbad, 0);
                end
            end
        end
        ml_prev <= map_loaded;
    end

    // Reference: walk the LFSR sequence from the first sampled value until an
    // index is in range and differs from the previous puzzle.
    task automatic issue_start(input bit seed, input logic [2:0] sv);
        int v, r, base, nz;
        wr_t w;
        done_t d;
        seed_en  = seed;
        seed_val = sv;
        start    = 1'b1;
        if (cyc >= model_done_cyc) begin
            if (seed)              v = int'(sv);
            else if (model_loaded) v = int'(lfsr);
            else                   v = next_of(int'(lfsr));
            r = 0;
            while (v >= NUM_MAPS || (have_prev && v == prev)) begin
                v = next_of(v);
                r++;
            end
            base = v * CELLS;
            nz = 0;
            for (int k = 0; k < CELLS; k++) begin
                w.cyc  = cyc + 3 + r + k;
                w.addr = k;
                w.data = int'(rom[base + k]);
                if (rom[base + k] != 4'd0) nz++;
                wr_q.push_back(w);
            end
            d.map   = v;
            d.cells = nz;
            d.cyc   = cyc + CELLS + 3 + r;
            done_q.push_back(d);
            model_done_cyc = d.cyc;
            prev = v;
            have_prev = 1'b1;
            model_loaded = 1'b1;
        end
        @(negedge clk);
        start   = 1'b0;
        seed_en = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((done_q.size() != 0 || wr_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            check("load_timeout", 1, 0);
            wr_q.delete();
            done_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int i = 0; i < 1024; i++)
            rom[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
        for (int k = 0; k < CELLS; k++) rom[CELLS + k] = 4'd0;
        for (int k = 0; k < 30; k++) rom[CELLS + (k * 8) % CELLS] = 4'($urandom_range(1, 9));
        for (int k = 0; k < 128; k++) board[k] = 4'd0;

        // Reset then idle.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_map_loaded", int'(map_loaded), 0);
        check("rst_board_we", int'(board_we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_board_addr", int'(board_addr), 0);
        check("rst_board_data", int'(board_data), 0);
        check("rst_map_select", int'(map_select), 0);
        check("rst_cells_given", int'(cells_given), 0);

        // First load: LFSR value 1 on the first SELECT cycle, no previous map.
        c0 = cyc;
        issue_start(1'b1, 3'd1);
        @(negedge clk);
        check("first_rom_addr", int'(rom_addr), 81);
        check("busy_in_read", int'(busy), 1);
        repeat (80) @(negedge clk);
        check("last_rom_addr", int'(rom_addr), 161);
        wait_done();
        check("load1_latency", ml_rise_cyc - c0, 84);
        check("load1_map", int'(map_select), 1);
        check("load1_clues", int'(cells_given), 30);

        // LFSR frozen at the previous index: that sample must be rejected.
        c0 = cyc;
        issue_start(1'b1, 3'd1);
        wait_done();
        check("load2_map", int'(map_select), 2);
        check("load2_differs", int'(map_select != 3'd1), 1);
        check("load2_latency", ml_rise_cyc - c0, 85);

        // Randomised loads, some with a stray start while busy.
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) issue_start(1'b1, 3'($urandom_range(1, 7)));
            else                            issue_start(1'b0, 3'd1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(5, 70)) @(negedge clk);
                issue_start(1'b0, 3'd1);
            end
            wait_done();
            check("rand_map_loaded", int'(map_loaded), 1);
        end

        // Reset during READ cycle 40, together with a start: reset wins.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        have_prev = 1'b0;
        model_loaded = 1'b0;
        model_done_cyc = 0;
        @(negedge clk);
        issue_start(1'b1, 3'd1);
        repeat (41) @(negedge clk);
        check("mid_board_we", int'(board_we), 1);
        reset = 1'b1;
        start = 1'b1;
        wr_q.delete();
        done_q.delete();
        have_prev = 1'b0;
        model_loaded = 1'b0;
        model_done_cyc = 0;
        @(negedge clk);
        check("midrst_board_we", int'(board_we), 0);
        check("midrst_map_loaded", int'(map_loaded), 0);
        check("midrst_busy", int'(busy), 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("midrst_still_idle", int'(busy), 0);
        issue_start(1'b0, 3'd1);
        wait_done();
        check("reload_map_loaded", int'(map_loaded), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
